// File: rtl/multi_dataflow_engine_pkg.sv
// Shared types and defaults for the multi-dataflow engine: FSM encoding,
// bus/counter widths and the engine / kernel-adapter control and flag structs.
package multi_dataflow_package;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned CNT_LEN_DEF    = 1024;
  localparam int unsigned CW_DEF         = $clog2(CNT_LEN_DEF) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic enable;
    logic clear;
    logic start;
  } engine_ctrl_t;

  typedef struct packed {
    logic idle;
    logic done;
    logic k_start;
  } engine_flags_t;

  typedef struct packed {
    logic load;
    logic drain;
  } kadp_ctrl_t;

  typedef struct packed {
    logic full;
  } kadp_flags_t;

endpackage

// File: rtl/multi_dataflow_out_slice.sv
// One-entry output register slice between the kernel result port and the
// output stream; a simultaneous drain and load keeps the slice full.
module multi_dataflow_out_slice
  import multi_dataflow_package::*;
#(
  parameter int unsigned DW = DATA_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  kadp_ctrl_t    ctrl,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output kadp_flags_t   flags
);

  logic full;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (ctrl.load) begin
      full <= 1'b1;
    end else if (ctrl.drain) begin
      full <= 1'b0;
    end
  end

  // Payload needs no reset; it is only observed while full.
  always_ff @(posedge clk) begin
    if (ctrl.load) begin
      dout <= din;
    end
  end

  assign flags.full = full;

endmodule

// File: rtl/multi_dataflow_engine.sv
// Job-controlled dataflow wrapper: forwards three input streams to a kernel
// during RUN and returns a bounded number of kernel results via a register slice.
module multi_dataflow_engine
  import multi_dataflow_package::*;
#(
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int unsigned CNT_LEN    = CNT_LEN_DEF,
  localparam int unsigned CW         = $clog2(CNT_LEN) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic [CW-1:0]         cnt_limit_i,

  input  logic [DATA_WIDTH-1:0] inStream0_data_i,
  input  logic                  inStream0_valid_i,
  output logic                  inStream0_ready_o,
  input  logic [DATA_WIDTH-1:0] inStream1_data_i,
  input  logic                  inStream1_valid_i,
  output logic                  inStream1_ready_o,
  input  logic [DATA_WIDTH-1:0] inStream2_data_i,
  input  logic                  inStream2_valid_i,
  output logic                  inStream2_ready_o,

  output logic [DATA_WIDTH-1:0] kIn0_data_o,
  output logic                  kIn0_valid_o,
  input  logic                  kIn0_ready_i,
  output logic [DATA_WIDTH-1:0] kIn1_data_o,
  output logic                  kIn1_valid_o,
  input  logic                  kIn1_ready_i,
  output logic [DATA_WIDTH-1:0] kIn2_data_o,
  output logic                  kIn2_valid_o,
  input  logic                  kIn2_ready_i,

  input  logic [DATA_WIDTH-1:0] kOut_data_i,
  input  logic                  kOut_valid_i,
  output logic                  kOut_ready_o,

  output logic [DATA_WIDTH-1:0] outStream0_data_o,
  output logic                  outStream0_valid_o,
  input  logic                  outStream0_ready_i,

  output logic                  k_start_o,
  output logic [CW-1:0]         cnt_o,
  output logic                  done_o,
  output logic                  idle_o
);

  engine_ctrl_t  ctrl;
  engine_flags_t flags;
  kadp_ctrl_t    kctl;
  kadp_flags_t   kflg;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] limit;
  logic [CW-1:0] pending;
  logic          run;
  logic          room;
  logic          limit_nz;
  logic          last_beat;

  assign ctrl = '{enable: enable_i, clear: rst_i | clear_i, start: start_i};

  assign run      = (state == ST_RUN) & ctrl.enable;
  assign limit_nz = (cnt_limit_i != '0);

  // Beats already delivered plus the one parked in the slice must stay below the limit.
  assign pending = cnt + CW'(kflg.full);
  assign room    = (pending < limit);

  assign kOut_ready_o = run & (~kflg.full | outStream0_ready_i) & room;
  assign kctl.load    = kOut_valid_i & kOut_ready_o;
  assign kctl.drain   = ctrl.enable & kflg.full & outStream0_ready_i;
  assign last_beat    = (state == ST_RUN) & kctl.drain & ((cnt + CW'(1)) == limit);

  // Next-state and decoded status flags.
  always_comb begin
    state_nxt     = state;
    flags         = '0;
    flags.idle    = (state == ST_IDLE);
    flags.done    = (state == ST_DONE);
    if (ctrl.enable) begin
      case (state)
        ST_IDLE: begin
          if (ctrl.start) begin
            state_nxt     = limit_nz ? ST_RUN : ST_DONE;
            flags.k_start = limit_nz & ~ctrl.clear;
          end
        end
        ST_RUN: begin
          if (last_beat) begin
            state_nxt = ST_DONE;
          end
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (ctrl.clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Job limit latch and saturating output-beat counter.
  always_ff @(posedge clk_i) begin
    if (ctrl.clear) begin
      cnt   <= '0;
      limit <= '0;
    end else if (ctrl.enable) begin
      if ((state == ST_IDLE) && ctrl.start) begin
        limit <= cnt_limit_i;
        cnt   <= '0;
      end else if (kctl.drain && (cnt < limit)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  multi_dataflow_out_slice #(
    .DW (DATA_WIDTH)
  ) u_out_slice (
    .clk   (clk_i),
    .rst   (ctrl.clear),
    .ctrl  (kctl),
    .din   (kOut_data_i),
    .dout  (outStream0_data_o),
    .flags (kflg)
  );

  assign outStream0_valid_o = kflg.full;

  // Input streams are wired straight through only while running and enabled.
  assign kIn0_data_o       = inStream0_data_i;
  assign kIn0_valid_o      = run & inStream0_valid_i;
  assign inStream0_ready_o = run & kIn0_ready_i;
  assign kIn1_data_o       = inStream1_data_i;
  assign kIn1_valid_o      = run & inStream1_valid_i;
  assign inStream1_ready_o = run & kIn1_ready_i;
  assign kIn2_data_o       = inStream2_data_i;
  assign kIn2_valid_o      = run & inStream2_valid_i;
  assign inStream2_ready_o = run & kIn2_ready_i;

  assign k_start_o = flags.k_start;
  assign done_o    = flags.done;
  assign idle_o    = flags.idle;
  assign cnt_o     = cnt;

endmodule
